// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: decoded operation codes, FSM states
// and the shift-op classifier.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_execute_stage_if.sv
// Valid/ready bus between the decoder, the execute stage and its consumer.
// The stage itself sits on the slave side.
interface alu_execute_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  alu_op_t          in_alu_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             busy;

  modport slave (
    input  in_valid, in_alu_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, busy
  );

  modport master (
    output in_valid, in_alu_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, busy
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative shifter: one bit position per clock, driven by a down-counter
// loaded with the shift amount.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter  int WIDTH   = ALU_WIDTH,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  alu_op_t            i_op,
  input  logic [WIDTH-1:0]   i_data_in,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_data_out
);

  alu_op_t            r_op;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_count;
  logic [WIDTH-1:0]   w_step;

  always_comb begin
    w_step = r_data;
    case (r_op)
      ALU_SLL: w_step = {r_data[WIDTH-2:0], 1'b0};
      ALU_SRL: w_step = {1'b0, r_data[WIDTH-1:1]};
      ALU_SRA: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
      default: w_step = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= ALU_NOP;
      r_data  <= '0;
      r_count <= '0;
    end else if (i_start) begin
      r_op    <= i_op;
      r_data  <= i_data_in;
      r_count <= i_shamt;
    end else if (r_count != '0) begin
      r_data  <= w_step;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

  // Done flags the last step: the caller captures the final shifted value
  // (w_step) on the same edge the counter reaches zero.
  assign o_done     = (r_count == SHAMT_W'(1));
  assign o_data_out = w_step;

endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage: single-cycle arithmetic/logic ops, multi-cycle shifts via
// alu_serial_shifter, registered result and zero flag behind valid/ready.
//
// state    | meaning
// ST_IDLE  | no result held, ready for a new op
// ST_SHIFT | serial shift in progress, input stalled
// ST_DONE  | result presented until the consumer takes it
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter  int WIDTH   = ALU_WIDTH,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_execute_stage_if.slave  bus
);

  exec_state_t        r_state;
  exec_state_t        w_next_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;

  logic [WIDTH-1:0]   w_alu_result;
  logic [WIDTH-1:0]   w_sh_data;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_shift_multi;
  logic               w_sh_done;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;
  logic               w_accept;
  logic               w_start;
  logic               w_load_alu;
  logic               w_load_sh;

  assign w_shamt       = bus.in_b[SHAMT_W-1:0];
  assign w_shift_multi = is_shift(bus.in_alu_op) && (w_shamt != '0);

  // Shifts only land here with a zero shift amount, so they pass A through.
  always_comb begin
    w_alu_result = '0;
    case (bus.in_alu_op)
      ALU_ADD: w_alu_result = bus.in_a + bus.in_b;
      ALU_SUB: w_alu_result = bus.in_a - bus.in_b;
      ALU_AND: w_alu_result = bus.in_a & bus.in_b;
      ALU_OR:  w_alu_result = bus.in_a | bus.in_b;
      ALU_XOR: w_alu_result = bus.in_a ^ bus.in_b;
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_result = bus.in_a;
      default: w_alu_result = '0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_SHIFT: begin
        w_busy = 1'b1;
        if (w_sh_done) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase

    // An accept from IDLE or from DONE (same-cycle handoff) overrides the above.
    w_accept   = bus.in_valid && w_in_ready;
    w_start    = w_accept && w_shift_multi;
    w_load_alu = w_accept && !w_shift_multi;
    w_load_sh  = (r_state == ST_SHIFT) && w_sh_done;
    if (w_accept) w_next_state = w_shift_multi ? ST_SHIFT : ST_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_load_alu) begin
      r_result <= w_alu_result;
      r_zero   <= (w_alu_result == '0);
    end else if (w_load_sh) begin
      r_result <= w_sh_data;
      r_zero   <= (w_sh_data == '0);
    end
  end

  alu_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_op       (bus.in_alu_op),
    .i_data_in  (bus.in_a),
    .i_shamt    (w_shamt),
    .o_done     (w_sh_done),
    .o_data_out (w_sh_data)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.busy       = w_busy;
  assign bus.out_result = r_result;
  assign bus.out_zero   = r_zero;

endmodule
